// File: rtl/fft_8p_frame_loader_if.sv
// Stream-in / frame-out bundle for fft_8p_frame_loader: serial complex samples in,
// packed N-point frame plus start/frame_err strobes out.
interface fft_8p_frame_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 8
);
    logic                          s_valid;
    logic                          s_ready;
    logic signed [DATA_WIDTH-1:0]  s_real;
    logic signed [DATA_WIDTH-1:0]  s_imag;
    logic                          s_last;
    logic                          start;
    logic [N*DATA_WIDTH-1:0]       x_real;
    logic [N*DATA_WIDTH-1:0]       x_imag;
    logic                          frame_err;

    modport master (
        output s_valid, s_real, s_imag, s_last,
        input  s_ready, start, x_real, x_imag, frame_err
    );

    modport slave (
        input  s_valid, s_real, s_imag, s_last,
        output s_ready, start, x_real, x_imag, frame_err
    );
endinterface

// File: rtl/fft_8p_frame_loader.sv
// Serial-to-parallel frame loader feeding fft_8p: fills an N-slot buffer, fires start, holds the frame.
// Define FFT_FRAME_LOADER_DBUF_EN for ping-pong buffering (fill next frame while the FFT consumes this one).
module fft_8p_frame_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int N           = 8,
    parameter int FFT_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    fft_8p_frame_loader_if.slave  bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (FFT_LATENCY > 1) ? $clog2(FFT_LATENCY) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FFT_LATENCY > 0) ? FFT_LATENCY - 1 : 0);
`ifdef FFT_FRAME_LOADER_DBUF_EN
    localparam logic DBUF = 1'b1;
`else
    localparam logic DBUF = 1'b0;
`endif

    typedef enum logic [1:0] {FILL, FIRE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             err_q, err_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             pend_q, pend_d;
    logic             pend_err_q, pend_err_d;
    logic             ready, beat, complete, free, fire, wr_en;

    logic [DATA_WIDTH-1:0] buf_real [2][N];
    logic [DATA_WIDTH-1:0] buf_imag [2][N];

    // A pending full bank blocks the writer; single-bank mode only accepts while filling.
`ifdef FFT_FRAME_LOADER_DBUF_EN
    assign ready = ~pend_q;
`else
    assign ready = (state_q == FILL);
`endif

    assign beat     = bus.s_valid & ready;
    assign complete = beat && (idx_q == IDX_LAST);
    assign free     = (state_q == FILL)
                   || (state_q == WAIT && cnt_q == CNT_LAST)
                   || (state_q == FIRE && FFT_LATENCY == 0);
    assign fire     = (complete || pend_q) && free;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        err_d      = 1'b0;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        pend_d     = pend_q;
        pend_err_d = pend_err_q;
        wr_en      = 1'b0;

        if (beat) begin
            if (complete) begin
                wr_en = 1'b1;
                idx_d = '0;
            end else if (bus.s_last) begin
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                idx_d = idx_q + 1'b1;
            end
        end

        case (state_q)
            FIRE: begin
                state_d = (FFT_LATENCY == 0) ? FILL : WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // The filled bank becomes the read bank; the writer moves to the other one.
        if (fire) begin
            state_d   = FIRE;
            cnt_d     = '0;
            start_d   = 1'b1;
            rd_bank_d = wr_bank_q;
            wr_bank_d = wr_bank_q ^ DBUF;
            pend_d    = 1'b0;
            err_d     = complete ? ~bus.s_last : pend_err_q;
        end else if (complete) begin
            pend_d     = 1'b1;
            pend_err_d = ~bus.s_last;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= FILL;
            idx_q      <= '0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            err_q      <= err_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            pend_q     <= pend_d;
            pend_err_q <= pend_err_d;
        end
    end

    // NOTE: the buffer is reset on purpose: the frame outputs must read zero right after reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    buf_real[b][k] <= '0;
                    buf_imag[b][k] <= '0;
                end
            end
        end else if (wr_en) begin
            buf_real[wr_bank_q][idx_q] <= bus.s_real;
            buf_imag[wr_bank_q][idx_q] <= bus.s_imag;
        end
    end

    always_comb begin
        bus.x_real = '0;
        bus.x_imag = '0;
        for (int k = 0; k < N; k++) begin
            bus.x_real[k*DATA_WIDTH +: DATA_WIDTH] = buf_real[rd_bank_q][k];
            bus.x_imag[k*DATA_WIDTH +: DATA_WIDTH] = buf_imag[rd_bank_q][k];
        end
    end

    assign bus.s_ready   = ready;
    assign bus.start     = start_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_fft_8p_frame_loader.sv
// Directed bench for fft_8p_frame_loader: table of whole-frame vectors plus hand-written
// sequences for partial frames, mid-frame reset and (with FFT_FRAME_LOADER_DBUF_EN) back-to-back frames.
module tb_fft_8p_frame_loader;
    localparam int DW  = 16;
    localparam int N   = 8;
    localparam int LAT = 2;
`ifdef FFT_FRAME_LOADER_DBUF_EN
    localparam int EXP_LOW = 0;
`else
    localparam int EXP_LOW = 1 + LAT;
`endif

    logic clk = 1'b0;
    logic arst_n = 1'b0;

    fft_8p_frame_loader_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    fft_8p_frame_loader #(.DATA_WIDTH(DW), .N(N), .FFT_LATENCY(LAT)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse-width monitor and start capture, sampled on the falling edge.
    logic prev_start = 1'b0;
    logic prev_err   = 1'b0;
    int   n_start    = 0;
    int   start_cyc[$];
    logic [N*DW-1:0] cap_re[$];
    logic [N*DW-1:0] cap_im[$];

    always @(negedge clk) begin
        if (prev_start) check("start_one_cycle", bus.start, 1'b0);
        if (prev_err)   check("err_one_cycle", bus.frame_err, 1'b0);
        if (bus.start === 1'b1) begin
            n_start++;
            start_cyc.push_back(cyc);
            cap_re.push_back(bus.x_real);
            cap_im.push_back(bus.x_imag);
        end
        prev_start = bus.start;
        prev_err   = bus.frame_err;
    end

    // Presents one sample, waits (bounded) for s_ready, returns at edge+1 after the beat.
    task automatic drive_beat(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        int waited = 0;
        bus.s_valid = 1'b1;
        bus.s_real  = re;
        bus.s_imag  = im;
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 20) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_timeout: s_ready is %b, expected 1", bus.s_ready);
                break;
            end
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        string                name;
        logic [N-1:0][DW-1:0] re;
        logic [N-1:0][DW-1:0] im;
        int                   last_at;
        bit                   gaps;
        bit                   exp_err;
        logic [N*DW-1:0]      exp_re;
        logic [N*DW-1:0]      exp_im;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int low;
        int n0;
        int s0;

        for (int k = 0; k < N; k++) begin
            vecs[0].re[k] = 16'(k + 1);
            vecs[0].im[k] = 16'(-(k + 1));
            vecs[1].re[k] = 16'h0100 + 16'(k);
            vecs[1].im[k] = 16'hA000 + 16'(k);
            vecs[2].re[k] = 16'h1230 + 16'(k);
            vecs[2].im[k] = 16'h7FF0 + 16'(k);
            vecs[3].re[k] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
            vecs[3].im[k] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
        end
        vecs[0].name = "ramp";     vecs[0].last_at = 7;  vecs[0].gaps = 0; vecs[0].exp_err = 0;
        vecs[0].exp_re = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        vecs[0].exp_im = 128'hFFF8_FFF9_FFFA_FFFB_FFFC_FFFD_FFFE_FFFF;
        vecs[1].name = "no_last";  vecs[1].last_at = -1; vecs[1].gaps = 0; vecs[1].exp_err = 1;
        vecs[1].exp_re = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
        vecs[1].exp_im = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
        vecs[2].name = "gaps";     vecs[2].last_at = 7;  vecs[2].gaps = 1; vecs[2].exp_err = 0;
        vecs[2].exp_re = 128'h1237_1236_1235_1234_1233_1232_1231_1230;
        vecs[2].exp_im = 128'h7FF7_7FF6_7FF5_7FF4_7FF3_7FF2_7FF1_7FF0;
        vecs[3].name = "extremes"; vecs[3].last_at = 7;  vecs[3].gaps = 0; vecs[3].exp_err = 0;
        vecs[3].exp_re = 128'h8000_7FFF_8000_7FFF_8000_7FFF_8000_7FFF;
        vecs[3].exp_im = 128'h7FFF_8000_7FFF_8000_7FFF_8000_7FFF_8000;

        bus.s_valid = 1'b0;
        bus.s_real  = '0;
        bus.s_imag  = '0;
        bus.s_last  = 1'b0;

        // Reset state
        #1;
        check("rst_start", bus.start, 1'b0);
        check("rst_err", bus.frame_err, 1'b0);
        check("rst_x_real", bus.x_real, '0);
        check("rst_x_imag", bus.x_imag, '0);
        idle(3);
        arst_n = 1'b1;
        idle(1);
        check("rst_ready", bus.s_ready, 1'b1);

        // Table-driven whole frames
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < N; k++) begin
                drive_beat(vecs[v].re[k], vecs[v].im[k], k == vecs[v].last_at);
                if (k != N - 1) begin
                    check({vecs[v].name, "_no_early_start"}, bus.start, 1'b0);
                    if (vecs[v].gaps) begin
                        bus.s_real = 16'hDEAD;
                        bus.s_imag = 16'hBEEF;
                        idle(1);
                    end
                end
            end
            check({vecs[v].name, "_start"}, bus.start, 1'b1);
            check({vecs[v].name, "_err"}, bus.frame_err, vecs[v].exp_err);
            check({vecs[v].name, "_x_real"}, bus.x_real, vecs[v].exp_re);
            check({vecs[v].name, "_x_imag"}, bus.x_imag, vecs[v].exp_im);
            low = 0;
            for (int i = 0; i < 5; i++) begin
                if (bus.s_ready === 1'b0) low++;
                if (i == 1) check({vecs[v].name, "_start_drop"}, bus.start, 1'b0);
                if (i == 2) check({vecs[v].name, "_x_real_held"}, bus.x_real, vecs[v].exp_re);
                idle(1);
            end
            check({vecs[v].name, "_ready_low_cycles"}, 128'(low), 128'(EXP_LOW));
        end

        // Partial frame dropped on early s_last, then a clean frame
        n0 = n_start;
        for (int k = 0; k < 3; k++) drive_beat(16'h0055, 16'h0066, k == 2);
        check("partial_err", bus.frame_err, 1'b1);
        check("partial_no_start", bus.start, 1'b0);
        check("partial_ready", bus.s_ready, 1'b1);
        for (int k = 0; k < N; k++) begin
            drive_beat(16'(10 + k), 16'h0200 + 16'(k), k == N - 1);
            if (k == 0) check("partial_err_drop", bus.frame_err, 1'b0);
        end
        check("after_partial_start", bus.start, 1'b1);
        check("after_partial_err", bus.frame_err, 1'b0);
        check("after_partial_x_real", bus.x_real, 128'h0011_0010_000F_000E_000D_000C_000B_000A);
        check("after_partial_x_imag", bus.x_imag, 128'h0207_0206_0205_0204_0203_0202_0201_0200);
        idle(5);
        check("partial_start_count", 128'(n_start - n0), 128'd1);

        // Reset while start and frame_err are high
        for (int k = 0; k < N; k++) drive_beat(16'h0300 + 16'(k), 16'h0400, 1'b0);
        check("pre_rst_start", bus.start, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        check("async_rst_start", bus.start, 1'b0);
        check("async_rst_err", bus.frame_err, 1'b0);
        check("async_rst_x_real", bus.x_real, '0);
        idle(2);
        arst_n = 1'b1;
        idle(1);

        // Reset in the middle of a frame, then a full-scale frame
        for (int k = 0; k < 5; k++) drive_beat(16'h0AAA, 16'h0BBB, 1'b0);
        #2 arst_n = 1'b0;
        idle(2);
        check("midrst_start", bus.start, 1'b0);
        check("midrst_err", bus.frame_err, 1'b0);
        check("midrst_x_imag", bus.x_imag, '0);
        arst_n = 1'b1;
        idle(1);
        for (int k = 0; k < N; k++) begin
            drive_beat(16'h7FFF, 16'h8000, k == N - 1);
            if (k != N - 1) check("midrst_no_early_start", bus.start, 1'b0);
        end
        check("midrst_frame_start", bus.start, 1'b1);
        check("midrst_frame_err", bus.frame_err, 1'b0);
        check("midrst_x_real", bus.x_real, {8{16'h7FFF}});
        check("midrst_x_imag2", bus.x_imag, {8{16'h8000}});
        idle(5);

`ifdef FFT_FRAME_LOADER_DBUF_EN
        // Three gapless frames through the ping-pong banks
        n0 = n_start;
        s0 = start_cyc.size();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                check("dbuf_ready", bus.s_ready, 1'b1);
                drive_beat(16'h0A00 + 16'(f * 256 + k), 16'h5000 + 16'(f * 256 + k), k == N - 1);
            end
        end
        idle(6);
        check("dbuf_start_count", 128'(n_start - n0), 128'd3);
        if (start_cyc.size() >= s0 + 3) begin
            check("dbuf_spacing_1", 128'(start_cyc[s0 + 1] - start_cyc[s0]), 128'd8);
            check("dbuf_spacing_2", 128'(start_cyc[s0 + 2] - start_cyc[s0 + 1]), 128'd8);
            check("dbuf_f0_re", cap_re[s0],     128'h0A07_0A06_0A05_0A04_0A03_0A02_0A01_0A00);
            check("dbuf_f0_im", cap_im[s0],     128'h5007_5006_5005_5004_5003_5002_5001_5000);
            check("dbuf_f1_re", cap_re[s0 + 1], 128'h0B07_0B06_0B05_0B04_0B03_0B02_0B01_0B00);
            check("dbuf_f1_im", cap_im[s0 + 1], 128'h5107_5106_5105_5104_5103_5102_5101_5100);
            check("dbuf_f2_re", cap_re[s0 + 2], 128'h0C07_0C06_0C05_0C04_0C03_0C02_0C01_0C00);
            check("dbuf_f2_im", cap_im[s0 + 2], 128'h5207_5206_5205_5204_5203_5202_5201_5200);
        end
`else
        s0 = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
